pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 36 +++
 rtl/pipe_ctrl_sat_counter.sv | 37 +++
 rtl/pipe_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: FSM state encodings and the
// per-cycle hazard classification used by pipe_ctrl and its benches.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    LDSTALL = 2'd2,
    FREEZE  = 2'd3
  } pipe_state_t;

  typedef enum logic [1:0] {
    CLS_NORMAL   = 2'd0,
    CLS_LOADUSE  = 2'd1,
    CLS_REDIRECT = 2'd2,
    CLS_FREEZE   = 2'd3
  } cycle_class_t;

  // Memory freeze dominates a redirect, which in turn discards a load-use stall.
  function automatic cycle_class_t classify(input logic stall,
                                            input logic branch_taken,
                                            input logic mem_busy);
    cycle_class_t cls;
    if (mem_busy) begin
      cls = CLS_FREEZE;
    end else if (branch_taken) begin
      cls = CLS_REDIRECT;
    end else if (stall) begin
      cls = CLS_LOADUSE;
    end else begin
      cls = CLS_NORMAL;
    end
    return cls;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
module pipe_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: step by one unless already pinned at all-ones.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/freeze controller for a 5-stage pipeline.
// Optional perf counters (stall/flush/freeze) are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 branch_taken_e,
  input  logic                 mem_busy_m,
  output logic                 pc_en,
  output logic                 fd_en,
  output logic                 de_en,
  output logic                 em_en,
  output logic                 mw_en,
  output logic                 fd_flush,
  output logic                 de_flush,
  output logic [1:0]           state_o,
  output logic                 stall_err
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output logic [CNT_WIDTH-1:0] freeze_cnt
`endif
);

  localparam int SLW = $clog2(MAX_STALL + 1) + 1;
  localparam logic [SLW-1:0] MAX_STALL_C = SLW'(MAX_STALL);
  localparam logic [SLW-1:0] SL_ONE      = {{(SLW-1){1'b0}}, 1'b1};

  pipe_state_t  state_q, state_d;
  cycle_class_t cls_s;
  logic [SLW-1:0] slen_q, slen_d;
  logic         err_q, err_d;

  // Next state, consecutive-stall tracking and the enable/flush set for this cycle.
  always_comb begin
    state_d  = state_q;
    slen_d   = slen_q;
    pc_en    = 1'b1;
    fd_en    = 1'b1;
    de_en    = 1'b1;
    em_en    = 1'b1;
    mw_en    = 1'b1;
    fd_flush = 1'b0;
    de_flush = 1'b0;
    cls_s    = classify(stall, branch_taken_e, mem_busy_m);
    if (state_q == INIT) begin
      pc_en    = 1'b0;
      fd_flush = 1'b1;
      de_flush = 1'b1;
      state_d  = RUN;
    end else begin
      case (cls_s)
        CLS_FREEZE: begin
          pc_en   = 1'b0;
          fd_en   = 1'b0;
          de_en   = 1'b0;
          em_en   = 1'b0;
          mw_en   = 1'b0;
          state_d = FREEZE;
        end
        CLS_REDIRECT: begin
          fd_flush = 1'b1;
          de_flush = 1'b1;
          slen_d   = {SLW{1'b0}};
          state_d  = RUN;
        end
        CLS_LOADUSE: begin
          // Hold PC and IF/ID, inject a bubble into ID/EX.
          pc_en    = 1'b0;
          fd_en    = 1'b0;
          de_flush = 1'b1;
          slen_d   = (slen_q == {SLW{1'b1}}) ? slen_q : slen_q + SL_ONE;
          state_d  = LDSTALL;
        end
        default: begin
          slen_d  = {SLW{1'b0}};
          state_d = RUN;
        end
      endcase
    end
    err_d = err_q | (slen_d > MAX_STALL_C);
  end

  // State, stall-length and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      slen_q  <= {SLW{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slen_q  <= slen_d;
      err_q   <= err_d;
    end
  end

  assign state_o   = state_q;
  assign stall_err = err_q;

`ifdef PIPE_PERF_CNT_EN
  logic active_s;
  assign active_s = (state_q != INIT);

  pipe_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (active_s && (cls_s == CLS_LOADUSE)),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (active_s && (cls_s == CLS_REDIRECT)),
    .count (flush_cnt)
  );

  pipe_sat_counter #(.WIDTH(CNT_WIDTH)) u_freeze_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (active_s && (cls_s == CLS_FREEZE)),
    .count (freeze_cnt)
  );
`endif

endmodule
